// File: rtl/lcd_ctrl_pkg.sv
// Shared types and constants for the HD44780 character LCD controller.
//   state_t      : controller FSM states
//   lcd_inst_t   : 9-bit LCD bus word, bit 8 = RS, bits 7:0 = DATA
//   DEF_T_*      : default timing in clk cycles (50 MHz reference)
//   init_rom()   : power-up instruction sequence
//   is_long_exec : instructions that need the long execution delay
package lcd_ctrl_pkg;

    localparam int unsigned DEF_T_POWERUP   = 750000;
    localparam int unsigned DEF_T_SETUP     = 2;
    localparam int unsigned DEF_T_EN        = 12;
    localparam int unsigned DEF_T_HOLD      = 2;
    localparam int unsigned DEF_T_EXEC      = 2000;
    localparam int unsigned DEF_T_EXEC_LONG = 82000;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned INIT_LEN = 6;
    localparam int unsigned STEP_W   = 3;

    typedef enum logic [2:0] {
        POWERUP,
        IDLE,
        SETUP,
        ENABLE,
        HOLD,
        EXEC,
        DONE
    } state_t;

    // Same layout as the lcd_inst_pkg 9-bit word: {rs, data}
    typedef struct packed {
        logic              rs;
        logic [DATA_W-1:0] data;
    } lcd_inst_t;

    // Function set 8-bit/2-line (x3), display on, entry mode, clear
    function automatic lcd_inst_t init_rom(input logic [STEP_W-1:0] idx);
        lcd_inst_t r;
        r.rs = 1'b0;
        case (idx)
            3'd0:    r.data = 8'h38;
            3'd1:    r.data = 8'h38;
            3'd2:    r.data = 8'h38;
            3'd3:    r.data = 8'h0C;
            3'd4:    r.data = 8'h06;
            3'd5:    r.data = 8'h01;
            default: r.data = 8'h00;
        endcase
        return r;
    endfunction

    // Clear display (0x01) and return home (0x02/0x03) run far longer
    function automatic logic is_long_exec(input lcd_inst_t i);
        return !i.rs && ((i.data == 8'h01) || (i.data == 8'h02) || (i.data == 8'h03));
    endfunction

    function automatic int unsigned umax(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_char_controller_if.sv
// Host slave bus of the LCD controller.
//   address     : 0 = instruction, 1 = character data
//   chipselect  : slave select
//   byteenable  : carried for bus compatibility, not used
//   read/write  : strobes (write wins when both are high)
//   writedata   : instruction or character byte
//   readdata    : status {busy, init_done, 6'b0}
//   response    : always OKAY
//   waitrequest : stall
interface lcd_char_controller_if;

    logic       address;
    logic       chipselect;
    logic       byteenable;
    logic       read;
    logic       write;
    logic [7:0] writedata;
    logic [7:0] readdata;
    logic [1:0] response;
    logic       waitrequest;

    modport master (
        output address, chipselect, byteenable, read, write, writedata,
        input  readdata, response, waitrequest
    );

    modport slave (
        input  address, chipselect, byteenable, read, write, writedata,
        output readdata, response, waitrequest
    );

endinterface

// File: rtl/lcd_delay_counter.sv
// Cycle delay timer shared by every timed controller state.
//   clk, reset : clock, async active-high reset
//   start      : one-cycle pulse in the first cycle of a timed state
//   load       : delay length in cycles (values 0 and 1 both mean one cycle)
//   expired_c  : one-cycle pulse in the last cycle of the delay
// The start cycle itself counts as cycle one, so a delay of N makes the
// owning state last exactly N cycles.
module lcd_delay_counter #(
    parameter int unsigned W = 20
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] load,
    output logic         expired_c
);

    logic [W-1:0] cnt;

    // Remaining cycles after the current one; saturates at zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= (load > W'(1)) ? load - W'(1) : '0;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign expired_c = start ? (load <= W'(1)) : (cnt == W'(1));

endmodule

// File: rtl/lcd_char_controller.sv
// HD44780 character LCD write controller with a stalling slave bus.
//   clk, reset : clock, async active-high reset
//   bus        : slave port (lcd_char_controller_if.slave)
//   LCD_DATA   : LCD data bus
//   LCD_RS     : register select
//   LCD_RW     : tied low, write-only
//   LCD_EN     : enable strobe
//   LCD_ON     : tied high
// After reset it waits T_POWERUP cycles, plays the init ROM, then accepts
// one host byte at a time. Each byte goes SETUP -> ENABLE -> HOLD -> EXEC;
// host writes finish with a single DONE cycle that releases waitrequest.
module lcd_char_controller
    import lcd_ctrl_pkg::*;
#(
    parameter int unsigned T_POWERUP   = DEF_T_POWERUP,
    parameter int unsigned T_SETUP     = DEF_T_SETUP,
    parameter int unsigned T_EN        = DEF_T_EN,
    parameter int unsigned T_HOLD      = DEF_T_HOLD,
    parameter int unsigned T_EXEC      = DEF_T_EXEC,
    parameter int unsigned T_EXEC_LONG = DEF_T_EXEC_LONG
) (
    input  logic                  clk,
    input  logic                  reset,
    lcd_char_controller_if.slave  bus,
    output logic [7:0]            LCD_DATA,
    output logic                  LCD_RS,
    output logic                  LCD_RW,
    output logic                  LCD_EN,
    output logic                  LCD_ON
);

    localparam int unsigned T_MAX = umax(umax(umax(T_POWERUP, T_EXEC_LONG), umax(T_EXEC, T_EN)),
                                         umax(T_SETUP, T_HOLD));
    localparam int unsigned CNT_W = $clog2(T_MAX + 1);
    localparam logic [STEP_W-1:0] INIT_LAST = STEP_W'(INIT_LEN - 1);

    state_t            state;
    logic [STEP_W-1:0] init_step;
    logic              init_done;
    lcd_inst_t         inst;
    logic              lcd_en;
    logic              dly_start;
    logic [CNT_W-1:0]  dly_load;
    logic              dly_exp_c;
    logic              unused_bus;

    lcd_delay_counter #(
        .W (CNT_W)
    ) u_delay (
        .clk       (clk),
        .reset     (reset),
        .start     (dly_start),
        .load      (dly_load),
        .expired_c (dly_exp_c)
    );

    // Controller FSM; dly_start/dly_load are issued together with each
    // timed-state entry so the counter starts in that state's first cycle.
    // Reset arms the power-up wait directly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= POWERUP;
            init_step <= '0;
            init_done <= 1'b0;
            inst      <= '0;
            lcd_en    <= 1'b0;
            dly_start <= 1'b1;
            dly_load  <= CNT_W'(T_POWERUP);
        end else begin
            dly_start <= 1'b0;
            unique case (state)
                POWERUP: begin
                    if (dly_exp_c) begin
                        inst      <= init_rom('0);
                        state     <= SETUP;
                        dly_start <= 1'b1;
                        dly_load  <= CNT_W'(T_SETUP);
                    end
                end
                IDLE: begin
                    // Write has priority over a simultaneous read
                    if (bus.chipselect && bus.write) begin
                        inst.rs   <= bus.address;
                        inst.data <= bus.writedata;
                        state     <= SETUP;
                        dly_start <= 1'b1;
                        dly_load  <= CNT_W'(T_SETUP);
                    end
                end
                SETUP: begin
                    if (dly_exp_c) begin
                        lcd_en    <= 1'b1;
                        state     <= ENABLE;
                        dly_start <= 1'b1;
                        dly_load  <= CNT_W'(T_EN);
                    end
                end
                ENABLE: begin
                    if (dly_exp_c) begin
                        lcd_en    <= 1'b0;
                        state     <= HOLD;
                        dly_start <= 1'b1;
                        dly_load  <= CNT_W'(T_HOLD);
                    end
                end
                HOLD: begin
                    if (dly_exp_c) begin
                        state     <= EXEC;
                        dly_start <= 1'b1;
                        dly_load  <= is_long_exec(inst) ? CNT_W'(T_EXEC_LONG) : CNT_W'(T_EXEC);
                    end
                end
                EXEC: begin
                    if (dly_exp_c) begin
                        if (init_done) begin
                            state <= DONE;
                        end else if (init_step == INIT_LAST) begin
                            init_done <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            // Next init byte; EN is low so RS/DATA may change here
                            init_step <= init_step + STEP_W'(1);
                            inst      <= init_rom(init_step + STEP_W'(1));
                            state     <= SETUP;
                            dly_start <= 1'b1;
                            dly_load  <= CNT_W'(T_SETUP);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= POWERUP;
                end
            endcase
        end
    end

    // Writes stall until their own DONE cycle; reads never stall
    assign bus.waitrequest = bus.chipselect & bus.write & (state != DONE);
    assign bus.readdata    = {(state != IDLE), init_done, 6'b0};
    assign bus.response    = 2'b00;

    assign unused_bus = ^{bus.byteenable, bus.read};

    assign LCD_DATA = inst.data;
    assign LCD_RS   = inst.rs;
    assign LCD_EN   = lcd_en;
    assign LCD_RW   = 1'b0;
    assign LCD_ON   = 1'b1;

endmodule

// File: doc/lcd_char_controller.md
LCD_CHAR_CONTROLLER -- requirements
Module: lcd_char_controller

Interface
REQ-001 SHALL have parameter T_POWERUP, default 750000, power-up wait in clk cycles (15 ms at 50 MHz).
REQ-002 SHALL have parameters T_SETUP=2, T_EN=12, T_HOLD=2: RS/DATA setup before EN, EN high width, and hold after EN falls, in cycles.
REQ-003 SHALL have parameters T_EXEC=2000 and T_EXEC_LONG=82000: post-write execution delay in cycles, normal and clear/home.
REQ-004 Ports SHALL be:
- clk  in  1  system clock; one clock domain; all logic on its rising edge.
- reset  in  1  asynchronous, active-high.
- address  in  1  0 = instruction, 1 = character data.
- chipselect  in  1  slave select.
- byteenable  in  1  ignored.
- read  in  1  read strobe.
- write  in  1  write strobe.
- writedata  in  8  instruction or character byte.
- readdata  out  8  status {busy, init_done, 6'b0}.
- response  out  2  always 2'b00.
- waitrequest  out  1  stall.
- LCD_DATA  out  8  HD44780 data bus.
- LCD_RS  out  1  register select.
- LCD_RW  out  1  constant 0; write-only.
- LCD_EN  out  1  enable strobe.
- LCD_ON  out  1  constant 1.

Function
REQ-005 FSM states SHALL be POWERUP, IDLE, SETUP, ENABLE, HOLD, EXEC, DONE.
REQ-006 POWERUP SHALL count T_POWERUP cycles, then issue the init sequence 0x38, 0x38, 0x38, 0x0C, 0x06, 0x01 (all RS=0) through SETUP->ENABLE->HOLD->EXEC, then enter IDLE with init_done=1.
REQ-007 SETUP SHALL drive LCD_RS/LCD_DATA with EN=0 for T_SETUP cycles; ENABLE SHALL hold EN=1 for T_EN cycles; HOLD SHALL keep RS/DATA stable with EN=0 for T_HOLD cycles.
REQ-008 EXEC SHALL wait T_EXEC_LONG if RS=0 and byte is 0x01, 0x02 or 0x03, else T_EXEC.
REQ-009 In IDLE, chipselect&write SHALL latch {address, writedata} on that edge and enter SETUP.
REQ-010 After a host write, EXEC SHALL go to DONE for exactly one cycle, then IDLE; after an init write, EXEC SHALL go to the next init step or to IDLE.
REQ-011 waitrequest SHALL be combinational: 1 when chipselect&write and state != DONE, else 0. The transfer completes in the DONE cycle.
REQ-012 A master holding write during init SHALL be stalled until its own transfer reaches DONE.
REQ-013 Reads SHALL never stall: waitrequest=0, readdata valid the same cycle, busy = (state != IDLE).
REQ-014 chipselect with read and write both high SHALL be treated as a write.
REQ-015 LCD_DATA/LCD_RS SHALL change only in IDLE->SETUP transitions or between init steps, never while EN=1.
REQ-016 Delay counters SHALL be wide enough for max(T_POWERUP, T_EXEC_LONG) with no wrap. A parameter of 1 SHALL give exactly one cycle.

Reset
REQ-017 Reset SHALL clear all state asynchronously: state=POWERUP, counters=0, init step=0, LCD_EN=0, LCD_RS=0, LCD_DATA=0x00, init_done=0.
REQ-018 Reset mid-operation, including with EN=1, SHALL drop LCD_EN immediately and restart the full power-up sequence.

Structure
REQ-019 Package lcd_ctrl_pkg SHALL hold the state typedef, default timing constants and the init ROM. The ROM SHALL use the existing lcd_inst_pkg 9-bit encoding, with bit 8 = RS.
REQ-020 Sub-module lcd_delay_counter SHALL be used: load value, start, and a one-cycle expired pulse. It SHALL serve all timed states.

Verification
REQ-021 Bench SHALL use T_POWERUP=20, T_SETUP=2, T_EN=3, T_HOLD=2, T_EXEC=5, T_EXEC_LONG=10.
REQ-022 Scenario, reset release: LCD_EN stays 0 for 20 cycles, then exactly six EN pulses carry data 38,38,38,0C,06,01 with RS=0, then readdata=0x40.
REQ-023 Scenario, data write after init: address=1, writedata=0x41 -> RS=1, DATA=0x41, EN high 3 cycles, waitrequest drops after 2+3+2+5 cycles plus the DONE cycle.
REQ-024 Scenario, clear write: address=0, writedata=0x01 -> EXEC lasts 10 cycles; writedata=0x0C -> EXEC lasts 5 cycles.
REQ-025 Scenario, write held from cycle 0: waitrequest stays 1 through all of init and the write completes afterwards. A read during init returns busy=1 with waitrequest=0.
REQ-026 Scenario, reset asserted during ENABLE: LCD_EN is 0 in the same cycle, and the power-up count restarts from 0.
